// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the TDC: start pulses, WAIT window, stream drain and best-hit reporting.
// Optional DRAIN watchdog enabled by defining TDC_CTRL_TIMEOUT_EN.
module tdc_meas_ctrl #(
    parameter int unsigned START_CYC   = 20,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        meas_req,
    input  logic [7:0]  cfg_frames,
    input  logic [15:0] cfg_win,
    output logic        TDC_start,
    input  logic [14:0] TDC_Odata,
    input  logic [4:0]  TDC_Oint,
    input  logic [1:0]  TDC_Onum,
    input  logic        TDC_Olast,
    input  logic        TDC_Ovalid,
    output logic        TDC_Oready,
    input  logic        TDC_INT,
    output logic [14:0] res_depth,
    output logic [4:0]  res_int,
    output logic [15:0] res_hits,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        meas_busy,
    output logic        done_irq,
    output logic        err_timeout
);

    localparam int unsigned HITS_W  = 16;
    localparam int unsigned SUM_W   = HITS_W + 1;
    localparam int unsigned FRM_W   = 8;
    localparam int unsigned WIN_W   = 16;
    // One cycle counter serves both the START pulse and the DRAIN watchdog.
    localparam int unsigned CNT_MAX = (START_CYC > TIMEOUT_CYC) ? START_CYC : TIMEOUT_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DRAIN,
        S_RESULT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [FRM_W-1:0] frames_q;
    logic [FRM_W-1:0] frame_cnt;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] cyc_cnt;
    logic [SUM_W-1:0] hits_sum;

    logic beat_acc;
    logic start_done;
    logic last_frame;
    logic frame_end;
    logic wdog_expired;
    logic cnt_run;

    logic tdc_start_d;
    logic oready_d;
    logic res_valid_d;
    logic busy_d;
    logic done_d;

    // Beat number field carries nothing this block needs.
    logic unused_onum;
    assign unused_onum = ^TDC_Onum;

    assign beat_acc   = TDC_Ovalid && TDC_Oready;
    assign start_done = (cyc_cnt == CNT_W'(START_CYC - 1));
    assign last_frame = (({1'b0, frame_cnt} + 9'd1) == {1'b0, frames_q});
    assign frame_end  = (beat_acc && TDC_Olast) || wdog_expired;
    assign hits_sum   = {1'b0, res_hits} + SUM_W'(TDC_Oint);

`ifdef TDC_CTRL_TIMEOUT_EN
    assign cnt_run      = (state == S_START) || (state == S_DRAIN);
    assign wdog_expired = (state == S_DRAIN) && !(beat_acc && TDC_Olast) &&
                          (cyc_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_timeout <= 1'b0;
        end else if (wdog_expired) begin
            err_timeout <= 1'b1;
        end
    end
`else
    assign cnt_run      = (state == S_START);
    assign wdog_expired = 1'b0;
    assign err_timeout  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (meas_req && !res_valid) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (start_done) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if ((win_cnt == '0) || TDC_INT) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (frame_end) begin
                    state_nxt = last_frame ? S_RESULT : S_START;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so registered outputs line up with the state.
    always_comb begin
        tdc_start_d = 1'b0;
        oready_d    = 1'b0;
        res_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        tdc_start_d = (state_nxt == S_START);
        oready_d    = (state_nxt == S_DRAIN);
        res_valid_d = (state_nxt == S_RESULT);
        busy_d      = (state_nxt != S_IDLE);
        done_d      = (state_nxt == S_RESULT) && (state != S_RESULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            TDC_start  <= 1'b0;
            TDC_Oready <= 1'b0;
            res_valid  <= 1'b0;
            meas_busy  <= 1'b0;
            done_irq   <= 1'b0;
        end else begin
            TDC_start  <= tdc_start_d;
            TDC_Oready <= oready_d;
            res_valid  <= res_valid_d;
            meas_busy  <= busy_d;
            done_irq   <= done_d;
        end
    end

    // Config latch, counters and result accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_q  <= '0;
            frame_cnt <= '0;
            win_q     <= '0;
            win_cnt   <= '0;
            cyc_cnt   <= '0;
            res_depth <= '0;
            res_int   <= '0;
            res_hits  <= '0;
        end else begin
            if (state_nxt != state) begin
                cyc_cnt <= '0;
            end else if (cnt_run) begin
                cyc_cnt <= cyc_cnt + CNT_W'(1);
            end

            if ((state == S_IDLE) && (state_nxt == S_START)) begin
                frames_q  <= (cfg_frames == 8'd0) ? 8'd1 : cfg_frames;
                win_q     <= cfg_win;
                frame_cnt <= '0;
                res_depth <= '0;
                res_int   <= '0;
                res_hits  <= '0;
            end

            if ((state == S_START) && (state_nxt == S_WAIT)) begin
                win_cnt <= win_q;
            end else if ((state == S_WAIT) && (win_cnt != '0)) begin
                win_cnt <= win_cnt - 16'd1;
            end

            if ((state == S_DRAIN) && beat_acc) begin
                res_hits <= hits_sum[HITS_W] ? 16'hFFFF : hits_sum[HITS_W-1:0];
                // Strict compare keeps the earlier beat on a tie.
                if (TDC_Oint > res_int) begin
                    res_int   <= TDC_Oint;
                    res_depth <= TDC_Odata;
                end
            end

            if ((state == S_DRAIN) && frame_end && !last_frame) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/tdc_meas_ctrl.md
TDC_MEAS_CTRL -- requirements
Module: tdc_meas_ctrl

Interface
REQ-001 Parameters: START_CYC, default 20, TDC_start pulse length in clk cycles; TIMEOUT_CYC, default 1024, drain watchdog limit in cycles.
REQ-002 clk  in  1  single clock shared with the tdc_top logic clock.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 meas_req  in  1  level request from core logic to run one measurement.
REQ-005 cfg_frames  in  8  frames per measurement; value 0 is treated as 1; latched on measurement start.
REQ-006 cfg_win  in  16  WAIT window length in cycles; latched on measurement start.
REQ-007 TDC_start  out  1  start pulse to the TDC.
REQ-008 TDC_Odata  in  15, TDC_Oint  in  5, TDC_Onum  in  2, TDC_Olast  in  1, TDC_Ovalid  in  1: TDC output stream.
REQ-009 TDC_Oready  out  1  stream ready to the TDC.
REQ-010 TDC_INT  in  1  TDC interrupt; ends the WAIT window early.
REQ-011 res_depth  out  15, res_int  out  5, res_hits  out  16, res_valid  out  1, res_ready  in  1: measurement result channel.
REQ-012 meas_busy  out  1; done_irq  out  1; err_timeout  out  1.

Function
REQ-013 The FSM SHALL have the states IDLE, START, WAIT, DRAIN and RESULT; meas_busy SHALL be 1 in every state except IDLE.
REQ-014 IDLE->START SHALL occur when meas_req=1 and res_valid=0; on this transition the block SHALL latch the cfg inputs, clear the accumulators and set frame_cnt=0.
REQ-015 In START, TDC_start SHALL be 1 for exactly START_CYC consecutive cycles; the next state SHALL be WAIT, with win_cnt loaded from the latched cfg_win.
REQ-016 In WAIT, win_cnt SHALL decrement by 1 per cycle; the FSM SHALL go to DRAIN when win_cnt==0 or TDC_INT==1; with cfg_win=0 the FSM SHALL spend exactly 1 cycle in WAIT.
REQ-017 TDC_Oready SHALL be 1 only in DRAIN; a beat SHALL be accepted only when TDC_Ovalid and TDC_Oready are both 1.
REQ-018 For each accepted beat, res_hits SHALL accumulate TDC_Oint, saturating at 0xFFFF.
REQ-019 For each accepted beat, if TDC_Oint > best_int, best_depth and best_int SHALL take the beat's values; on a tie the earlier beat SHALL be kept.
REQ-020 TDC_Onum SHALL be ignored.
REQ-021 An accepted beat with TDC_Olast=1 SHALL end the frame: if frame_cnt+1 == frames the FSM SHALL go to RESULT; otherwise frame_cnt SHALL increment and the FSM SHALL go to START.
REQ-022 A frame in which no beat has Oint greater than the current best SHALL leave best_depth and best_int unchanged.
REQ-023 In RESULT, res_valid SHALL be 1, and res_depth, res_int and res_hits SHALL be stable until the cycle in which res_ready=1; in that cycle the FSM SHALL go to IDLE and res_valid SHALL fall on the next cycle.
REQ-024 done_irq SHALL be a 1-cycle pulse in the first cycle of RESULT.
REQ-025 meas_req SHALL be ignored outside IDLE; cfg changes after latching SHALL have no effect on the running measurement.
REQ-026 If no beat is accepted in a measurement, the result SHALL be res_depth=0, res_int=0, res_hits=0.

Reset
REQ-027 While rst=1 at a clk edge: state SHALL be IDLE; TDC_start, TDC_Oready, res_valid, done_irq, err_timeout and meas_busy SHALL be 0; res_depth, res_int, res_hits and all counters SHALL be 0.
REQ-028 rst asserted mid-measurement SHALL abort the measurement immediately, with no done_irq pulse; TDC_start SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-029 With the macro TDC_CTRL_TIMEOUT_EN defined: a DRAIN watchdog SHALL count cycles without an accepted Olast beat.
REQ-030 The watchdog SHALL be cleared on entry to DRAIN; when it reaches TIMEOUT_CYC, the block SHALL set err_timeout (sticky until rst), treat the frame as ended, and continue per REQ-021.
REQ-031 Without TDC_CTRL_TIMEOUT_EN: there SHALL be no watchdog logic, err_timeout SHALL be tied to 0, and DRAIN SHALL wait indefinitely for an Olast beat.

Verification
REQ-032 cfg_frames=1, cfg_win=50, one beat (depth 0x123, Oint 1, Olast) -> TDC_start high for 20 cycles; res_depth=0x123, res_int=1, res_hits=1; one done_irq pulse.
REQ-033 cfg_frames=5, Oint per frame 1,5,9,11,7 (depths D1..D5) -> res_depth=D4, res_int=11, res_hits=33; 5 TDC_start pulses.
REQ-034 TDC_INT=1 at WAIT cycle 3 with cfg_win=100 -> DRAIN entered at cycle 4; TDC_Oready=1 from that cycle.
REQ-035 res_ready held 0 for 10 cycles in RESULT -> res_valid and result outputs stable; a new meas_req is not accepted until 1 cycle after the handshake.
REQ-036 With TDC_CTRL_TIMEOUT_EN defined, Ovalid held 0 in DRAIN -> err_timeout=1 after 1024 cycles; result=0/0/0; done_irq pulses.
REQ-037 rst=1 during WAIT of frame 2 -> all outputs 0 on the next cycle; no done_irq pulse.
